// File: rtl/l1_store_queue_if.sv
// l1_store_queue_if -- bus bundle between the L1 store queue, the core
// store/load pipe and the L2 store path.
//   master : core + L2 side (drives stores, bypass lookups, ack, responses)
//   slave  : store queue side (drives bypass results, rollback, L2 request,
//            wake and empty bitmaps)
interface l1_store_queue_if #(
  parameter int NUM_THREADS = 4,
  parameter int LINE_BYTES  = 64,
  parameter int ADDR_WIDTH  = 32
);
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic                    dd_store_en;
  logic [ADDR_WIDTH-1:0]   dd_store_addr;
  logic [LINE_BYTES-1:0]   dd_store_mask;
  logic [LINE_BYTES*8-1:0] dd_store_data;
  logic [TW-1:0]           dd_store_thread_idx;
  logic [ADDR_WIDTH-1:0]   dd_store_bypass_addr;
  logic [TW-1:0]           dd_store_bypass_thread_idx;
  logic [LINE_BYTES-1:0]   sb_store_bypass_mask;
  logic [LINE_BYTES*8-1:0] sb_store_bypass_data;
  logic                    sb_full_rollback;
  logic                    sb_dequeue_ready;
  logic                    sb_dequeue_ack;
  logic [TW-1:0]           sb_dequeue_idx;
  logic [ADDR_WIDTH-1:0]   sb_dequeue_addr;
  logic [LINE_BYTES-1:0]   sb_dequeue_mask;
  logic [LINE_BYTES*8-1:0] sb_dequeue_data;
  logic                    storebuf_l2_response_valid;
  logic [TW-1:0]           storebuf_l2_response_idx;
  logic [NUM_THREADS-1:0]  sb_wake_bitmap;
  logic [NUM_THREADS-1:0]  sb_thread_empty;

  modport master (
    output dd_store_en, dd_store_addr, dd_store_mask, dd_store_data,
           dd_store_thread_idx, dd_store_bypass_addr, dd_store_bypass_thread_idx,
           sb_dequeue_ack, storebuf_l2_response_valid, storebuf_l2_response_idx,
    input  sb_store_bypass_mask, sb_store_bypass_data, sb_full_rollback,
           sb_dequeue_ready, sb_dequeue_idx, sb_dequeue_addr, sb_dequeue_mask,
           sb_dequeue_data, sb_wake_bitmap, sb_thread_empty
  );

  modport slave (
    input  dd_store_en, dd_store_addr, dd_store_mask, dd_store_data,
           dd_store_thread_idx, dd_store_bypass_addr, dd_store_bypass_thread_idx,
           sb_dequeue_ack, storebuf_l2_response_valid, storebuf_l2_response_idx,
    output sb_store_bypass_mask, sb_store_bypass_data, sb_full_rollback,
           sb_dequeue_ready, sb_dequeue_idx, sb_dequeue_addr, sb_dequeue_mask,
           sb_dequeue_data, sb_wake_bitmap, sb_thread_empty
  );
endinterface

// File: rtl/l1_store_queue.sv
// l1_store_queue -- per-thread write-combining store queue in front of L2.
//   clk, reset : clock, synchronous active-high reset
//   bus        : l1_store_queue_if.slave (store input, load bypass lookup,
//                round-robin L2 request with ack, L2 completions, wake/empty)
// l1_sq_thread holds one thread's circular queue; the top decodes the thread
// index, arbitrates the L2 request and registers the bypass/rollback results.

module l1_sq_thread #(
  parameter int ENTRIES    = 4,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_WIDTH = 32
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_en,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [LINE_BYTES-1:0]   st_mask,
  input  logic [LINE_BYTES*8-1:0] st_data,
  input  logic                    deq_fire,
  input  logic                    rsp,
  input  logic [ADDR_WIDTH-1:0]   byp_addr,
  output logic [ADDR_WIDTH-1:0]   snd_addr,
  output logic [LINE_BYTES-1:0]   snd_mask,
  output logic [LINE_BYTES*8-1:0] snd_data,
  output logic                    has_unsent,
  output logic                    empty,
  output logic                    reject,
  output logic                    wake,
  output logic [LINE_BYTES-1:0]   byp_mask,
  output logic [LINE_BYTES*8-1:0] byp_data
);
  localparam int PW = $clog2(ENTRIES);
  localparam logic [PW:0] FULL = (PW+1)'(ENTRIES);

  logic [ENTRIES-1:0]                            valid, sent;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0]            addr;
  logic [ENTRIES-1:0][LINE_BYTES-1:0]            mask;
  logic [ENTRIES-1:0][LINE_BYTES-1:0][7:0]       data;
  logic [PW-1:0] head, snd, tail, youngest, wi, bidx;
  logic [PW:0]   count;
  logic          waiting, combine, alloc, free;

  assign youngest = tail - 1'b1;
  // Merge only into an unsent youngest entry that is not leaving this cycle.
  assign combine  = st_en && (count != '0) && valid[youngest] && !sent[youngest] &&
                    (addr[youngest] == st_addr) && !(deq_fire && (snd == youngest));
  // Full check uses the pre-response count: a same-cycle free does not help.
  assign alloc    = st_en && !combine && (count != FULL);
  assign reject   = st_en && !combine && (count == FULL);
  assign free     = rsp && valid[head] && sent[head];
  assign wi       = combine ? youngest : tail;

  // Entries between send pointer and tail are exactly the unsent ones.
  assign has_unsent = valid[snd] && !sent[snd];
  assign empty      = (count == '0);
  assign wake       = rsp && waiting;
  assign snd_addr   = addr[snd];
  assign snd_mask   = mask[snd];
  assign snd_data   = data[snd];

  // Walk oldest to youngest so younger bytes overwrite older ones.
  always_comb begin
    byp_mask = '0;
    byp_data = '0;
    bidx     = head;
    for (int i = 0; i < ENTRIES; i++) begin
      bidx = head + PW'(i);
      if (valid[bidx] && (addr[bidx] == byp_addr)) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
          if (mask[bidx][b]) begin
            byp_mask[b]         = 1'b1;
            byp_data[b*8 +: 8]  = data[bidx][b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= '0;
      sent    <= '0;
      head    <= '0;
      snd     <= '0;
      tail    <= '0;
      count   <= '0;
      waiting <= 1'b0;
    end else begin
      if (combine || alloc) begin
        for (int b = 0; b < LINE_BYTES; b++)
          if (st_mask[b]) data[wi][b] <= st_data[b*8 +: 8];
        mask[wi] <= combine ? (mask[wi] | st_mask) : st_mask;
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        sent[tail]  <= 1'b0;
        addr[tail]  <= st_addr;
        tail        <= tail + 1'b1;
      end
      if (deq_fire) begin
        sent[snd] <= 1'b1;
        snd       <= snd + 1'b1;
      end
      if (free) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, free};
      // A fresh rejection re-arms the flag even if a wake fires this cycle.
      if (reject)   waiting <= 1'b1;
      else if (rsp) waiting <= 1'b0;
    end
  end

  a_rsp_has_sent: assert property (@(posedge clk) disable iff (reset)
    rsp |-> (valid[head] && sent[head]));
endmodule

module l1_store_queue #(
  parameter int NUM_THREADS        = 4,
  parameter int ENTRIES_PER_THREAD = 4,
  parameter int LINE_BYTES         = 64,
  parameter int ADDR_WIDTH         = 32
)(
  input logic             clk,
  input logic             reset,
  l1_store_queue_if.slave bus
);
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int DW = LINE_BYTES * 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

  logic [ADDR_WIDTH-1:0] st_addr, byp_addr;
  logic [NUM_THREADS-1:0] t_st_en, t_deq, t_rsp, t_unsent, t_empty, t_reject, t_wake;
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] t_snd_addr;
  logic [NUM_THREADS-1:0][LINE_BYTES-1:0] t_snd_mask, t_byp_mask;
  logic [NUM_THREADS-1:0][DW-1:0]         t_snd_data, t_byp_data;
  logic [TW-1:0] rr_ptr, win;
  logic          found, fire;

  assign st_addr  = bus.dd_store_addr & LINE_MASK;
  assign byp_addr = bus.dd_store_bypass_addr & LINE_MASK;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
    assign t_st_en[g] = bus.dd_store_en && (bus.dd_store_thread_idx == TW'(g));
    assign t_deq[g]   = fire && (win == TW'(g));
    assign t_rsp[g]   = bus.storebuf_l2_response_valid &&
                        (bus.storebuf_l2_response_idx == TW'(g));

    l1_sq_thread #(
      .ENTRIES(ENTRIES_PER_THREAD), .LINE_BYTES(LINE_BYTES), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_thr (
      .clk       (clk),
      .reset     (reset),
      .st_en     (t_st_en[g]),
      .st_addr   (st_addr),
      .st_mask   (bus.dd_store_mask),
      .st_data   (bus.dd_store_data),
      .deq_fire  (t_deq[g]),
      .rsp       (t_rsp[g]),
      .byp_addr  (byp_addr),
      .snd_addr  (t_snd_addr[g]),
      .snd_mask  (t_snd_mask[g]),
      .snd_data  (t_snd_data[g]),
      .has_unsent(t_unsent[g]),
      .empty     (t_empty[g]),
      .reject    (t_reject[g]),
      .wake      (t_wake[g]),
      .byp_mask  (t_byp_mask[g]),
      .byp_data  (t_byp_data[g])
    );
  end

  // Round-robin: first candidate at or after rr_ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      int c;
      c = (int'(rr_ptr) + i) % NUM_THREADS;
      if (!found && t_unsent[c]) begin
        found = 1'b1;
        win   = TW'(c);
      end
    end
  end

  assign fire                 = found && bus.sb_dequeue_ack;
  assign bus.sb_dequeue_ready = found;
  assign bus.sb_dequeue_idx   = win;
  assign bus.sb_dequeue_addr  = t_snd_addr[win];
  assign bus.sb_dequeue_mask  = t_snd_mask[win];
  assign bus.sb_dequeue_data  = t_snd_data[win];
  assign bus.sb_wake_bitmap   = t_wake;
  assign bus.sb_thread_empty  = t_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr                   <= '0;
      bus.sb_full_rollback     <= 1'b0;
      bus.sb_store_bypass_mask <= '0;
      bus.sb_store_bypass_data <= '0;
    end else begin
      if (fire) rr_ptr <= (win == TW'(NUM_THREADS - 1)) ? '0 : win + 1'b1;
      bus.sb_full_rollback     <= |t_reject;
      bus.sb_store_bypass_mask <= t_byp_mask[bus.dd_store_bypass_thread_idx];
      bus.sb_store_bypass_data <= t_byp_data[bus.dd_store_bypass_thread_idx];
    end
  end
endmodule
